// File: rtl/pwm_duty_meter.sv
// Receive side of the humidity PWM link: measures high time and period of an
// asynchronous PWM input and reports a rounded duty level in tens of percent.
module pwm_duty_meter #(
  parameter int unsigned CNT_W   = 28,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [3:0]       duty10,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned REM_W = CNT_W + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             s_q;
  logic             s_prev_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] snap_hi_q;
  logic [CNT_W-1:0] snap_per_q;
  logic [REM_W-1:0] rem_q;
  logic [3:0]       quot_q;

  logic             rise;
  logic             timed_out;
  logic             can_sub;
  logic [REM_W-1:0] rem_load;

  assign rise      = s_q & ~s_prev_q;
  assign timed_out = (state_q != IDLE) && (per_q == CNT_W'(TIMEOUT));
  // Adding half the period before dividing gives round-half-up.
  assign rem_load  = REM_W'(hi_q) * REM_W'(10) + REM_W'(per_q >> 1);
  assign can_sub   = (rem_q >= REM_W'(snap_per_q)) && (quot_q < 4'd10);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      s_q        <= 1'b0;
      s_prev_q   <= 1'b0;
      per_q      <= '0;
      hi_q       <= '0;
      snap_hi_q  <= '0;
      snap_per_q <= '0;
      rem_q      <= '0;
      quot_q     <= 4'd0;
      high_cnt   <= '0;
      period_cnt <= '0;
      duty10     <= 4'd0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1_q  <= pwm_in;
      s_q      <= sync1_q;
      s_prev_q <= s_q;
      valid    <= 1'b0;

      // The rise cycle itself is high, so both counters restart at one.
      if (rise) begin
        per_q <= CNT_W'(1);
        hi_q  <= CNT_W'(1);
      end else if (state_q != IDLE) begin
        per_q <= per_q + CNT_W'(1);
        hi_q  <= hi_q + CNT_W'(s_q);
      end

      if (rise) begin
        if (state_q == IDLE) begin
          state_q <= MEAS;
        end else begin
          snap_hi_q  <= hi_q;
          snap_per_q <= per_q;
          rem_q      <= rem_load;
          quot_q     <= 4'd0;
          state_q    <= DIV;
          busy       <= 1'b1;
        end
      end else if (timed_out) begin
        duty10     <= s_q ? 4'd10 : 4'd0;
        high_cnt   <= '0;
        period_cnt <= '0;
        timeout    <= 1'b1;
        valid      <= 1'b1;
        state_q    <= IDLE;
        busy       <= 1'b0;
      end else if (state_q == DIV) begin
        if (can_sub) begin
          rem_q  <= rem_q - REM_W'(snap_per_q);
          quot_q <= quot_q + 4'd1;
        end else begin
          duty10     <= quot_q;
          high_cnt   <= snap_hi_q;
          period_cnt <= snap_per_q;
          timeout    <= 1'b0;
          valid      <= 1'b1;
          state_q    <= MEAS;
          busy       <= 1'b0;
        end
      end
    end
  end

endmodule
